mcycle_sequencer: RTL and testbench

- Iterative unsigned multiply/divide engine with its own control FSM. It is the resource behind the pipeline's M_Start/M_Busy/M_Done handshake.
- Accepts one operation from the Execute stage and runs it over WIDTH cycles without holding the pipeline.
- Reports the pending destination register (WA3R) so hazard logic can stall only dependent instructions.
- Produces a one-cycle Done pulse with the result, during which the pipeline writes back.

---
 rtl/mcycle_sequencer.sv | 113 +++++++++++
 tb/tb_mcycle_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_sequencer.sv
// Iterative unsigned multiply/divide engine behind the M_Start/M_Busy/M_Done handshake.
// One shift-add or restoring-divide step per cycle, WIDTH steps per operation.
module mcycle_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             M_Start,
  input  logic             M_Op,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3E,
  output logic             M_Busy,
  output logic             M_Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       WA3R
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             opDiv;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor
  logic [WIDTH:0]   hi;        // product high word / remainder R
  logic [WIDTH-1:0] lo;        // multiplier shift reg / quotient Q
  logic [WIDTH:0]   hiNext;
  logic [WIDTH-1:0] loNext;
  logic             lastIter;

  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   remSh;
  logic [WIDTH+1:0] trial;

  assign lastIter = (cnt == CNT_W'(WIDTH - 1));

  // Single-step datapath; hi[WIDTH] stays zero in multiply mode so the add cannot overflow.
  always_comb begin
    addSum = hi + {1'b0, (lo[0] ? opnd : '0)};
    remSh  = {hi[WIDTH-1:0], lo[WIDTH-1]};
    trial  = {1'b0, remSh} - {2'b0, opnd};
    hiNext = hi;
    loNext = lo;
    if (!opDiv) begin
      hiNext = {1'b0, addSum[WIDTH:1]};
      loNext = {addSum[0], lo[WIDTH-1:1]};
    end else if (trial[WIDTH+1]) begin
      hiNext = remSh;
      loNext = {lo[WIDTH-2:0], 1'b0};
    end else begin
      hiNext = trial[WIDTH:0];
      loNext = {lo[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    stateNext = state;
    M_Busy    = 1'b0;
    M_Done    = 1'b0;
    case (state)
      IDLE: if (M_Start) stateNext = RUN;
      RUN: begin
        M_Busy = 1'b1;
        if (lastIter) stateNext = DONE;
      end
      DONE: begin
        M_Done    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      opDiv    <= 1'b0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      Result   <= '0;
      ResultHi <= '0;
      WA3R     <= 4'hF;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (M_Start) begin
          opDiv <= M_Op;
          opnd  <= M_Op ? Operand2 : Operand1;
          lo    <= M_Op ? Operand1 : Operand2;
          hi    <= '0;
          cnt   <= '0;
          WA3R  <= WA3E;
        end
        RUN: begin
          hi  <= hiNext;
          lo  <= loNext;
          cnt <= cnt + 1'b1;
          // Result regs only move on completion so IDLE shows the last finished value.
          if (lastIter) begin
            Result   <= loNext;
            ResultHi <= hiNext[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Bench for mcycle_sequencer: vector table, random ops vs native arithmetic, and
// hand-written start-ignore / hold-across-DONE / mid-op reset sequences.
module tb_mcycle_sequencer;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         M_Start = 1'b0;
  logic         M_Op = 1'b0;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [3:0]   WA3E = '0;
  logic         M_Busy, M_Done;
  logic [W-1:0] Result, ResultHi;
  logic [3:0]   WA3R;

  mcycle_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .M_Start(M_Start), .M_Op(M_Op),
    .Operand1(Operand1), .Operand2(Operand2), .WA3E(WA3E),
    .M_Busy(M_Busy), .M_Done(M_Done), .Result(Result), .ResultHi(ResultHi), .WA3R(WA3R)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   wa;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   wa;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  exp_t sb[$];
  exp_t monE;
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every Done pulse pops one expected result.
  always @(negedge CLK) begin
    if (!Reset) begin
      chk("busy_done_exclusive", {63'b0, M_Busy & M_Done}, 64'd0);
      if (M_Busy && sb.size() > 0) chk("wa3r_in_flight", WA3R, sb[0].wa);
      if (M_Done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got Done pulse expected none at %0t", $time);
        end else begin
          monE = sb.pop_front();
          chk("result", Result, monE.lo);
          chk("resultHi", ResultHi, monE.hi);
          chk("wa3r_done", WA3R, monE.wa);
        end
      end
    end
  end

  // Issue one op from a negedge, scramble inputs afterwards, and wait for Done.
  task automatic runOp(input vec_t v);
    int n = 0;
    int busyN = 0;
    M_Start = 1'b1; M_Op = v.op; Operand1 = v.a; Operand2 = v.b; WA3E = v.wa;
    sb.push_back('{v.lo, v.hi, v.wa});
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge CLK);
      if (i == 1) begin
        M_Start = 1'b0; Operand1 = ~v.a; Operand2 = ~v.b; WA3E = ~v.wa;
      end
      if (M_Busy) busyN++;
      if (M_Done) n = i;
    end
    chk("latency", n, 33);
    chk("busy_cycles", busyN, 32);
    @(negedge CLK);
  endtask

  function automatic vec_t model(input logic op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [3:0] wa);
    vec_t v;
    logic [63:0] p;
    v.op = op; v.a = a; v.b = b; v.wa = wa;
    p = {32'b0, a} * {32'b0, b};
    if (!op) begin
      v.lo = p[31:0]; v.hi = p[63:32];
    end else if (b == 0) begin
      v.lo = '1; v.hi = a;
    end else begin
      v.lo = a / b; v.hi = a % b;
    end
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int spurious;
    vecs[0] = '{1'b0, 32'h0000_0007, 32'h0000_0006, 4'h5, 32'h0000_002A, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{1'b1, 32'd100,       32'd7,         4'h9, 32'd14,        32'd2};
    vecs[3] = '{1'b1, 32'h0000_1234, 32'h0000_0000, 4'h2, 32'hFFFF_FFFF, 32'h0000_1234};
    vecs[4] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 4'hA, 32'h0000_0000, 32'h0000_0001};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'h1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'd5,         32'd9,         4'h0, 32'd0,         32'd5};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h7, 32'h0000_0000, 32'h8000_0000};

    #12;
    chk("rst_busy", M_Busy, 0);
    chk("rst_done", M_Done, 0);
    chk("rst_result", Result, 0);
    chk("rst_resultHi", ResultHi, 0);
    chk("rst_wa3r", WA3R, 4'hF);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);

    foreach (vecs[i]) runOp(vecs[i]);

    for (int k = 0; k < 4; k++)
      runOp(model(k[0], $urandom, (k == 3) ? 32'd0 : $urandom, 4'(k + 11)));

    // A start pulse during RUN must not disturb the running op or queue a new one.
    M_Start = 1'b1; M_Op = 1'b0; Operand1 = 32'h1234; Operand2 = 32'h10; WA3E = 4'h6;
    sb.push_back('{32'h0001_2340, 32'h0, 4'h6});
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge CLK);
      if (i == 1) M_Start = 1'b0;
      if (i == 5) begin
        M_Start = 1'b1; M_Op = 1'b1; Operand1 = 32'd99; Operand2 = 32'd3; WA3E = 4'hC;
      end
      if (i == 6) M_Start = 1'b0;
      if (M_Done) n = i;
    end
    chk("ignore_latency", n, 33);
    repeat (3) begin
      @(negedge CLK);
      chk("ignore_no_restart", M_Busy, 0);
    end

    // Start held through DONE is picked up only once back in IDLE.
    M_Start = 1'b1; M_Op = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5; WA3E = 4'h4;
    sb.push_back('{32'd15, 32'd0, 4'h4});
    sb.push_back('{32'd100, 32'd0, 4'h8});
    @(negedge CLK);
    M_Op = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd10; WA3E = 4'h8;
    n = 0;
    for (int i = 2; i <= 40 && n == 0; i++) begin
      @(negedge CLK);
      if (M_Done) n = i;
    end
    chk("hold_first_latency", n, 33);
    @(negedge CLK);
    chk("hold_idle_busy", M_Busy, 0);
    @(negedge CLK);
    chk("hold_restart_busy", M_Busy, 1);
    M_Start = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge CLK);
      if (M_Done) n = i;
    end
    chk("hold_second_latency", n, 32);
    @(negedge CLK);

    // Asynchronous reset at iteration 10 discards the op with no Done afterwards.
    M_Start = 1'b1; M_Op = 1'b0; Operand1 = 32'd9; Operand2 = 32'd9; WA3E = 4'hB;
    @(negedge CLK);
    M_Start = 1'b0;
    repeat (9) @(negedge CLK);
    chk("pre_reset_busy", M_Busy, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_busy", M_Busy, 0);
    chk("async_rst_done", M_Done, 0);
    chk("async_rst_wa3r", WA3R, 4'hF);
    chk("async_rst_result", Result, 0);
    chk("async_rst_resultHi", ResultHi, 0);
    @(negedge CLK);
    Reset = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge CLK);
      if (M_Done || M_Busy) spurious++;
    end
    chk("no_activity_after_reset", spurious, 0);
    runOp(model(1'b1, 32'd77, 32'd5, 4'h3));

    // Back-to-back multiply then divide.
    runOp(model(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 4'hD));
    runOp(model(1'b1, 32'hFFFE_0001, 32'h0000_FFFF, 4'hE));

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
